// File: rtl/matrix_pkg.sv
// Shared constants and state type for the HUB75 32x32 scan driver.
package matrix_pkg;

    localparam int unsigned ROWS_HALF = 16;
    localparam int unsigned COLS      = 32;
    localparam int unsigned SLOTS     = 33;
    localparam int unsigned SLOT_W    = 6;

    typedef enum logic [1:0] {
        SHIFT,
        BLANK,
        LATCH
    } scan_state_t;

endpackage

// File: rtl/scan_phase_ctr.sv
// Phase/slot counter pair pacing one row shift: DIV phases per slot, SLOTS slots per row.
module scan_phase_ctr
    import matrix_pkg::*;
#(
    parameter int unsigned DIV = 4,
    localparam int unsigned PW = $clog2(DIV)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    output logic [PW-1:0]     phase,
    output logic [SLOT_W-1:0] slot,
    output logic              sample_pulse,
    output logic              slot_done
);

    localparam logic [PW-1:0]     PHASE_LAST    = PW'(DIV - 1);
    localparam logic [SLOT_W-1:0] SLOT_LAST     = SLOT_W'(SLOTS - 1);
    localparam logic [SLOT_W-1:0] SLOT_PIX_LAST = SLOT_W'(COLS - 1);

    logic last_phase;

    assign last_phase = (phase == PHASE_LAST);

    // Wraps back to slot 0 / phase 0 after the last slot so the next row starts clean.
    always_ff @(posedge clk) begin
        if (reset) begin
            phase <= '0;
            slot  <= '0;
        end else if (en) begin
            if (last_phase) begin
                phase <= '0;
                slot  <= (slot == SLOT_LAST) ? '0 : slot + 1'b1;
            end else begin
                phase <= phase + 1'b1;
            end
        end
    end

    assign sample_pulse = en && last_phase && (slot <= SLOT_PIX_LAST);
    assign slot_done    = en && last_phase && (slot == SLOT_LAST);

endmodule

// File: rtl/matrix_scan.sv
// HUB75 1/16-scan driver: fetches pixels from the renderer and shifts/latches them to the panel.
module matrix_scan
    import matrix_pkg::*;
#(
    parameter int unsigned DIV       = 4,
    parameter int unsigned PIX_LAT   = 1,
    parameter int unsigned BLANK_CYC = 2
) (
    input  logic       clk,
    input  logic       reset,
    output logic [3:0] row,
    output logic [4:0] col,
    input  logic       RED_UP_WIRE,
    input  logic       GREEN_UP_WIRE,
    input  logic       BLUE_UP_WIRE,
    input  logic       RED_DOWN_WIRE,
    input  logic       GREEN_DOWN_WIRE,
    input  logic       BLUE_DOWN_WIRE,
    output logic       r1,
    output logic       g1,
    output logic       b1,
    output logic       r2,
    output logic       g2,
    output logic       b2,
    output logic       panel_clk,
    output logic       lat,
    output logic       oe_n,
    output logic [3:0] addr,
    output logic       frame_start
);

    localparam int unsigned PW = $clog2(DIV);
    localparam int unsigned BW = (BLANK_CYC > 1) ? $clog2(BLANK_CYC) : 1;
    localparam logic [BW-1:0] BLANK_LAST = BW'((BLANK_CYC > 0) ? BLANK_CYC - 1 : 0);
    localparam logic [PW-1:0] PHASE_LAST = PW'(DIV - 1);
    localparam logic [4:0]    COL_LAST   = 5'(COLS - 1);
    localparam logic [3:0]    ROW_LAST   = 4'(ROWS_HALF - 1);

    if (DIV < 2 || DIV % 2 != 0 || PIX_LAT > DIV - 1) begin : g_bad_cfg
        $error("matrix_scan: DIV must be even and >= 2, PIX_LAT must be <= DIV-1");
    end

    scan_state_t       state, state_d;
    logic [PW-1:0]     phase;
    logic [SLOT_W-1:0] slot;
    logic              sample_pulse, slot_done;
    logic [BW-1:0]     blank_cnt, blank_cnt_d;
    logic              shown, shown_d;
    logic [3:0]        row_d, addr_d;
    logic [4:0]        col_d;
    logic              panel_clk_d, lat_d, oe_n_d, frame_start_d;

    scan_phase_ctr #(
        .DIV (DIV)
    ) u_ctr (
        .clk          (clk),
        .reset        (reset),
        .en           (state == SHIFT),
        .phase        (phase),
        .slot         (slot),
        .sample_pulse (sample_pulse),
        .slot_done    (slot_done)
    );

    always_comb begin
        state_d     = state;
        blank_cnt_d = blank_cnt;
        unique case (state)
            SHIFT: begin
                if (slot_done) begin
                    state_d     = (BLANK_CYC == 0) ? LATCH : BLANK;
                    blank_cnt_d = '0;
                end
            end
            BLANK: begin
                if (blank_cnt == BLANK_LAST) begin
                    state_d = LATCH;
                end else begin
                    blank_cnt_d = blank_cnt + 1'b1;
                end
            end
            LATCH:   state_d = SHIFT;
            default: state_d = SHIFT;
        endcase
    end

    // Every pin is registered, so each output is derived from where the FSM is headed next.
    always_comb begin
        row_d   = row;
        col_d   = col;
        addr_d  = addr;
        shown_d = shown;
        if (sample_pulse && col != COL_LAST) begin
            col_d = col + 5'd1;
        end
        if (slot_done) begin
            addr_d = row;
        end
        if (state == LATCH) begin
            row_d   = (row == ROW_LAST) ? 4'd0 : row + 4'd1;
            col_d   = '0;
            shown_d = 1'b1;
        end
        // High for the upper half of slots 1..32: phase+1 lands in DIV/2..DIV-1 within the slot.
        panel_clk_d = (state == SHIFT) && (slot != '0) && (phase != PHASE_LAST)
                      && (32'(phase) + 32'd1 >= DIV / 2);
        lat_d         = (state_d == LATCH);
        oe_n_d        = !((state_d == SHIFT) && shown_d);
        frame_start_d = (state == SHIFT) && (slot == '0) && (phase == '0) && (row == 4'd0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= SHIFT;
            blank_cnt   <= '0;
            shown       <= 1'b0;
            row         <= '0;
            col         <= '0;
            addr        <= '0;
            {r1, g1, b1, r2, g2, b2} <= '0;
            panel_clk   <= 1'b0;
            lat         <= 1'b0;
            oe_n        <= 1'b1;
            frame_start <= 1'b0;
        end else begin
            state       <= state_d;
            blank_cnt   <= blank_cnt_d;
            shown       <= shown_d;
            row         <= row_d;
            col         <= col_d;
            addr        <= addr_d;
            if (sample_pulse) begin
                {r1, g1, b1} <= {RED_UP_WIRE, GREEN_UP_WIRE, BLUE_UP_WIRE};
                {r2, g2, b2} <= {RED_DOWN_WIRE, GREEN_DOWN_WIRE, BLUE_DOWN_WIRE};
            end
            panel_clk   <= panel_clk_d;
            lat         <= lat_d;
            oe_n        <= oe_n_d;
            frame_start <= frame_start_d;
        end
    end

endmodule

// File: tb/tb_matrix_scan.sv
// Directed bench for matrix_scan: default instance plus a DIV=2/BLANK_CYC=0 instance.
module tb_matrix_scan;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic [3:0] row, addr, row_b, addr_b;
    logic [4:0] col, col_b;
    logic       r1, g1, b1, r2, g2, b2, panel_clk, lat, oe_n, frame_start;
    logic       r1_b, g1_b, b1_b, r2_b, g2_b, b2_b;
    logic       panel_clk_b, lat_b, oe_n_b, frame_start_b;
    logic [2:0] up_in, dn_in, up_in_b, dn_in_b;

    int vectors = 0;
    int miscompares = 0;

    int cyc, rises_a, rises_b, row_exp, rows_a, rows_b, last_fs, nfs;
    logic track;
    logic prev_pclk_a, prev_pclk_b;
    logic [3:0] prev_addr_a, prev_addr_b;

    function automatic logic [2:0] pix(input int r, input int c);
        int v;
        v = r * 5 + c * 3 + (r / 16) * 3 + c / 4;
        return v[2:0];
    endfunction

    // Renderer model with one cycle of address-to-colour latency.
    always @(posedge clk) begin
        up_in   <= pix(int'(row), int'(col));
        dn_in   <= pix(int'(row) + 16, int'(col));
        up_in_b <= pix(int'(row_b), int'(col_b));
        dn_in_b <= pix(int'(row_b) + 16, int'(col_b));
    end

    matrix_scan u_dut (
        .clk             (clk),
        .reset           (reset),
        .row             (row),
        .col             (col),
        .RED_UP_WIRE     (up_in[2]),
        .GREEN_UP_WIRE   (up_in[1]),
        .BLUE_UP_WIRE    (up_in[0]),
        .RED_DOWN_WIRE   (dn_in[2]),
        .GREEN_DOWN_WIRE (dn_in[1]),
        .BLUE_DOWN_WIRE  (dn_in[0]),
        .r1              (r1),
        .g1              (g1),
        .b1              (b1),
        .r2              (r2),
        .g2              (g2),
        .b2              (b2),
        .panel_clk       (panel_clk),
        .lat             (lat),
        .oe_n            (oe_n),
        .addr            (addr),
        .frame_start     (frame_start)
    );

    matrix_scan #(
        .DIV       (2),
        .PIX_LAT   (1),
        .BLANK_CYC (0)
    ) u_dut_b (
        .clk             (clk),
        .reset           (reset),
        .row             (row_b),
        .col             (col_b),
        .RED_UP_WIRE     (up_in_b[2]),
        .GREEN_UP_WIRE   (up_in_b[1]),
        .BLUE_UP_WIRE    (up_in_b[0]),
        .RED_DOWN_WIRE   (dn_in_b[2]),
        .GREEN_DOWN_WIRE (dn_in_b[1]),
        .BLUE_DOWN_WIRE  (dn_in_b[0]),
        .r1              (r1_b),
        .g1              (g1_b),
        .b1              (b1_b),
        .r2              (r2_b),
        .g2              (g2_b),
        .b2              (b2_b),
        .panel_clk       (panel_clk_b),
        .lat             (lat_b),
        .oe_n            (oe_n_b),
        .addr            (addr_b),
        .frame_start     (frame_start_b)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One clock: sample at the falling edge, then run invariant and tracking checks.
    task automatic step();
        @(negedge clk);
        cyc++;
        if (addr !== prev_addr_a) chk("addr_change_oe_a", int'(oe_n), 1);
        if (addr_b !== prev_addr_b) chk("addr_change_oe_b", int'(oe_n_b), 1);
        if (lat) begin
            chk("lat_vs_pclk_a", int'(panel_clk), 0);
            chk("lat_vs_oe_a", int'(oe_n), 1);
        end
        if (lat_b) begin
            chk("lat_vs_pclk_b", int'(panel_clk_b), 0);
            chk("lat_vs_oe_b", int'(oe_n_b), 1);
        end
        if (track) begin
            if (panel_clk && !prev_pclk_a) begin
                chk("pix_up", int'({r1, g1, b1}), int'(pix(row_exp, rises_a)));
                chk("pix_dn", int'({r2, g2, b2}), int'(pix(row_exp + 16, rises_a)));
                rises_a++;
            end
            if (rows_a == 0) chk("oe_row0_dark", int'(oe_n), 1);
            if (rows_a == 1 && cyc < 135 + 132) chk("oe_row1_lit", int'(oe_n), 0);
            if (lat) begin
                chk("rises_per_row_a", rises_a, 32);
                chk("lat_cycle_a", cyc, rows_a * 135 + 134);
                chk("addr_at_latch_a", int'(addr), row_exp);
                rises_a = 0;
                row_exp = (row_exp + 1) % 16;
                rows_a++;
            end
            if (frame_start) begin
                if (nfs == 0) chk("frame_start_first", cyc, 1);
                else chk("frame_start_period", cyc - last_fs, 2160);
                last_fs = cyc;
                nfs++;
            end
            if (panel_clk_b && !prev_pclk_b) rises_b++;
            if (lat_b) begin
                chk("rises_per_row_b", rises_b, 32);
                chk("lat_cycle_b", cyc, rows_b * 67 + 66);
                chk("lat_after_last_shift_b", int'(prev_pclk_b), 1);
                rises_b = 0;
                rows_b++;
            end
        end
        prev_pclk_a = panel_clk;
        prev_pclk_b = panel_clk_b;
        prev_addr_a = addr;
        prev_addr_b = addr_b;
    endtask

    initial begin
        int found;
        track = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("rst_row", int'(row), 0);
        chk("rst_col", int'(col), 0);
        chk("rst_addr", int'(addr), 0);
        chk("rst_colour", int'({r1, g1, b1, r2, g2, b2}), 0);
        chk("rst_pclk", int'(panel_clk), 0);
        chk("rst_lat", int'(lat), 0);
        chk("rst_oe_n", int'(oe_n), 1);
        chk("rst_frame_start", int'(frame_start), 0);
        chk("rst_oe_n_b", int'(oe_n_b), 1);

        @(posedge clk);
        #1 reset = 1'b0;
        cyc = -1;
        rises_a = 0;
        rises_b = 0;
        row_exp = 0;
        rows_a = 0;
        rows_b = 0;
        last_fs = 0;
        nfs = 0;
        prev_pclk_a = panel_clk;
        prev_pclk_b = panel_clk_b;
        prev_addr_a = addr;
        prev_addr_b = addr_b;
        track = 1'b1;

        repeat (2300) step();
        chk("rows_latched_a", rows_a, 17);
        chk("frame_starts_seen", nfs, 2);
        chk("rows_latched_b", rows_b, 34);

        // Reset in the middle of row 7's latch cycle.
        found = 0;
        for (int i = 0; i < 1500; i++) begin
            step();
            if (lat && row == 4'd7) begin
                found = 1;
                break;
            end
        end
        chk("reached_latch_row7", found, 1);
        track = 1'b0;
        reset = 1'b1;
        step();
        chk("midrst_oe_n", int'(oe_n), 1);
        chk("midrst_lat", int'(lat), 0);
        chk("midrst_row", int'(row), 0);
        chk("midrst_col", int'(col), 0);
        reset = 1'b0;
        step();
        chk("midrst_frame_start", int'(frame_start), 1);
        repeat (20) step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/matrix_scan.md
# matrix_scan

Scan driver for the 32×32 HUB75 LED matrix. It sits directly downstream of `action`:
- It drives the `row`/`col` pixel address into `action`.
- It captures the six colour bits `action` returns.
- It serialises them onto the panel's shift/latch/blank pins at 1/16 scan, upper and lower halves in parallel.

It also emits a once-per-frame tick for game logic timing.

## Interface
Parameters:
- `DIV`, 4: clock cycles per pixel slot; must be even and ≥ 2.
- `PIX_LAT`, 1: cycles from a `row`/`col` change to valid colour bits at the input; must be ≤ `DIV`-1.
- `BLANK_CYC`, 2: cycles `oe_n` is held high before each latch.

Ports:
- Clock and reset: one clock; reset is synchronous and active-high.
  - `clk`  in  1  system clock.
  - `reset`  in  1  synchronous, active-high reset.
- Pixel address to `action`:
  - `row`  out  4  row being shifted, 0..15.
  - `col`  out  5  column being requested, 0..31.
- Colour bits from `action`:
  - `RED_UP_WIRE`, `GREEN_UP_WIRE`, `BLUE_UP_WIRE`  in  1 each  colour for pixel (`row`, `col`).
  - `RED_DOWN_WIRE`, `GREEN_DOWN_WIRE`, `BLUE_DOWN_WIRE`  in  1 each  colour for pixel (`row`+16, `col`).
- Panel pins:
  - `r1`, `g1`, `b1`, `r2`, `g2`, `b2`  out  1 each  panel data pins.
  - `panel_clk`  out  1  panel shift clock.
  - `lat`  out  1  panel latch.
  - `oe_n`  out  1  panel output enable, active-low.
  - `addr`  out  4  panel row address (A..D).
- `frame_start`  out  1  single-cycle pulse at the start of each frame.

## Operation
- States: `SHIFT` → `BLANK` → `LATCH` → `SHIFT`. Reset enters `SHIFT` with `row`=0.
- `SHIFT`:
  - Runs 33 slots, s = 0..32, each of `DIV` phases, p = 0..`DIV`-1.
  - `col` = s for s ≤ 31. `col` holds 31 during slot 32.
  - At the last phase of slots 0..31, register the six colour inputs into `r1`..`b2`. The new values appear at phase 0 of the next slot.
  - `panel_clk` = 1 for phases `DIV`/2..`DIV`-1 of slots 1..32, otherwise 0. This gives exactly 32 rising edges per row. Pixel k is shifted on the edge in slot k+1.
- `BLANK`:
  - `oe_n` = 1 for `BLANK_CYC` cycles.
  - `addr` ← `row` on the first `BLANK` cycle.
  - `panel_clk` = 0 throughout.
- `LATCH`:
  - `lat` = 1 for exactly one cycle, with `oe_n` still 1.
  - On exit, `row` ← `row`+1 with modulo-16 wrap (15→0), `col` ← 0, and the `shown` flag is set.
- `oe_n` = 0 during `SHIFT` only when `shown` = 1; otherwise it is 1.
  - `shown` is cleared by reset, so the panel stays dark until the first row has been latched.
- `frame_start` = 1 on the first cycle of every `SHIFT` with `row`=0, including the first cycle after reset deasserts.
- Colour inputs are ignored outside the sample phase.

## Timing
- Row period = 33·`DIV` + `BLANK_CYC` + 1 cycles. With defaults: 135 cycles per row and 2160 cycles per frame.
- Sample-to-pin latency is 1 cycle.
- Address-to-sample spacing is `DIV`-1 cycles, which must be ≥ `PIX_LAT`.
- All outputs are registered. There are no combinational paths from inputs to outputs.
- Reset values:
  - `row`=0, `col`=0, `addr`=0.
  - `r1`..`b2`=0, `panel_clk`=0, `lat`=0.
  - `oe_n`=1, `frame_start`=0.
  - Phase and slot counters = 0; state = `SHIFT`; `shown`=0.
- Reset asserted mid-row, including during `LATCH`:
  - All outputs take their reset values at the next edge.
  - No partial `lat` pulse is extended.
- `lat` never coincides with `panel_clk`=1 or `oe_n`=0.
- `addr` changes only while `oe_n`=1.

## Structure
- Shared package `matrix_pkg` holds:
  - `ROWS_HALF`=16 and `COLS`=32.
  - The state enum `scan_state_t` with values `SHIFT`, `BLANK`, `LATCH`.
  - The `SLOTS`=33 constant.
- One sub-module, `scan_phase_ctr`:
  - A phase/slot counter pair with `clk`, `reset` and `en` inputs.
  - Outputs `phase`, `slot`, `sample_pulse` and `slot_done`.
- The FSM, output registers and `frame_start` logic stay in `matrix_scan`.

## Test plan
- Reset, then run 1 row with defaults:
  - Exactly 32 `panel_clk` rises.
  - `lat` high for 1 cycle at cycle 134 after reset release.
  - `oe_n`=1 throughout the first row, then 0 in row 1.
- Pixel model: a `row`/`col` → colour function with `PIX_LAT`=1, driven for a full frame. The pixel value on `r1`..`b2` at each `panel_clk` rise must equal the model for (`row`, k) and (`row`+16, k).
- Frame timing: `frame_start` pulses must be spaced 2160 cycles apart, and `addr` must step 0..15 and wrap to 0.
- Non-default parameters `DIV`=2, `BLANK_CYC`=0, `PIX_LAT`=1: row period must be 67 cycles, with `lat` immediately after the final shift slot.
- Assert `reset` during `LATCH` of row 7: next cycle `oe_n`=1, `lat`=0, `row`=0; the following cycle `frame_start`=1.
- Checker over all runs: `addr` changes only while `oe_n`=1, and `lat`=1 never overlaps `panel_clk`=1.
